// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: program counter, level-based imem request and the IF/ID register.
// A one-entry skid buffer keeps a word returned during a stall so it is delivered exactly once.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_branch_taken,
  input  logic [31:0] In_BTA,
  input  logic        In_jump,
  input  logic [31:0] In_Jump_Address,
  input  logic        In_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_instruction,
  output logic [31:0] IFID_pc_plus_4,
  output logic        IFID_valid,
  output logic        misalign_err
);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] skid_r, skid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pp4_r, pp4_s;
  logic        valid_r, valid_s;
  logic        mis_r, mis_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect decode: jump takes precedence over a simultaneous taken branch.
  always_comb begin
    redirect_s = In_branch_taken | In_jump;
    pc_inc_s   = pc_r + 32'd4;
    if (In_jump) begin
      target_s = In_Jump_Address;
    end else begin
      target_s = In_BTA;
    end
  end

  // Next-state and next-register logic; redirect overrides stall and fetch completion.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    skid_s  = skid_r;
    instr_s = instr_r;
    pp4_s   = pp4_r;
    valid_s = valid_r;
    mis_s   = mis_r;
    if (redirect_s) begin
      pc_s    = word_align(target_s);
      instr_s = NOP_INSTR;
      valid_s = 1'b0;
      mis_s   = mis_r | word_misaligned(target_s);
      state_s = ST_REQ;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (imem_ready && !In_stall) begin
            instr_s = imem_rdata;
            pp4_s   = pc_inc_s;
            valid_s = 1'b1;
            pc_s    = pc_inc_s;
          end else if (imem_ready && In_stall) begin
            skid_s  = imem_rdata;
            state_s = ST_HELD;
          end else if (!In_stall) begin
            valid_s = 1'b0;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_HELD: begin
          if (!In_stall) begin
            instr_s = skid_r;
            pp4_s   = pc_inc_s;
            valid_s = 1'b1;
            pc_s    = pc_inc_s;
            state_s = ST_REQ;
          end else begin
            state_s = ST_HELD;
          end
        end
        default: begin
          state_s = ST_REQ;
        end
      endcase
    end
  end

  // State register; reset clears the skid and FSM immediately so nothing buffered escapes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_REQ;
      pc_r    <= RESET_PC;
      skid_r  <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
      pp4_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
      mis_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      skid_r  <= skid_s;
      instr_r <= instr_s;
      pp4_r   <= pp4_s;
      valid_r <= valid_s;
      mis_r   <= mis_s;
    end
  end

  // Request depends only on state, gated low while reset is held.
  assign imem_req         = (state_r == ST_REQ) && !reset;
  assign imem_addr        = pc_r;
  assign PC               = pc_r;
  assign IFID_instruction = instr_r;
  assign IFID_pc_plus_4   = pp4_r;
  assign IFID_valid       = valid_r;
  assign misalign_err     = mis_r;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: two instances (RESET_PC 0 and 0xFFFF_FFFC) share stimulus and are
// compared every cycle against a word-availability reference model, plus directed scenario checks.
module tb_fetch_pc_stage;

  logic        clk;
  logic        rst;
  logic        br, jmp, stall, rdy;
  logic [31:0] bta, ja;

  logic        req0, req1, vld0, vld1, mis0, mis1;
  logic [31:0] addr0, addr1, rdata0, rdata1, pc0, pc1, ins0, ins1, pp40, pp41;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] SCRAMBLE = 32'hC0DE_0000;
  localparam logic [31:0] RP1      = 32'hFFFF_FFFC;

  // reference model state per instance
  logic [31:0] m_pc[2], m_skid[2], m_ins[2], m_pp4[2], m_rp[2];
  logic        m_hold[2], m_vld[2], m_mis[2];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ SCRAMBLE;
  endfunction

  assign rdata0 = mem(addr0);
  assign rdata1 = mem(addr1);

  fetch_pc_stage dut0 (
    .clk(clk), .reset(rst), .In_branch_taken(br), .In_BTA(bta), .In_jump(jmp),
    .In_Jump_Address(ja), .In_stall(stall), .imem_req(req0), .imem_addr(addr0),
    .imem_ready(rdy), .imem_rdata(rdata0), .PC(pc0), .IFID_instruction(ins0),
    .IFID_pc_plus_4(pp40), .IFID_valid(vld0), .misalign_err(mis0)
  );

  fetch_pc_stage #(.RESET_PC(RP1)) dut1 (
    .clk(clk), .reset(rst), .In_branch_taken(br), .In_BTA(bta), .In_jump(jmp),
    .In_Jump_Address(ja), .In_stall(stall), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(rdy), .imem_rdata(rdata1), .PC(pc1), .IFID_instruction(ins1),
    .IFID_pc_plus_4(pp41), .IFID_valid(vld1), .misalign_err(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of the model: a word is available from the skid or from a ready memory.
  task automatic model_step(input int d);
    logic        have;
    logic [31:0] word, tgt;
    if (rst) begin
      m_pc[d] = m_rp[d]; m_hold[d] = 1'b0; m_skid[d] = 32'h0;
      m_ins[d] = 32'h0; m_pp4[d] = 32'h0; m_vld[d] = 1'b0; m_mis[d] = 1'b0;
    end else if (br || jmp) begin
      tgt = jmp ? ja : bta;
      if (tgt % 4 != 0) m_mis[d] = 1'b1;
      m_pc[d] = tgt - (tgt % 4);
      m_ins[d] = 32'h0; m_vld[d] = 1'b0; m_hold[d] = 1'b0;
    end else begin
      have = m_hold[d] || rdy;
      word = m_hold[d] ? m_skid[d] : mem(m_pc[d]);
      if (!stall) begin
        if (have) begin
          m_ins[d] = word; m_pp4[d] = m_pc[d] + 32'd4; m_vld[d] = 1'b1;
          m_pc[d] = m_pc[d] + 32'd4; m_hold[d] = 1'b0;
        end else begin
          m_vld[d] = 1'b0;
        end
      end else if (have && !m_hold[d]) begin
        m_skid[d] = word; m_hold[d] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc0", pc0, m_pc[0]);          chk("pc1", pc1, m_pc[1]);
    chk("addr0", addr0, m_pc[0]);      chk("addr1", addr1, m_pc[1]);
    chk("req0", {31'h0, req0}, {31'h0, !rst && !m_hold[0]});
    chk("req1", {31'h0, req1}, {31'h0, !rst && !m_hold[1]});
    chk("ins0", ins0, m_ins[0]);       chk("ins1", ins1, m_ins[1]);
    chk("pp4_0", pp40, m_pp4[0]);      chk("pp4_1", pp41, m_pp4[1]);
    chk("vld0", {31'h0, vld0}, {31'h0, m_vld[0]});
    chk("vld1", {31'h0, vld1}, {31'h0, m_vld[1]});
    chk("mis0", {31'h0, mis0}, {31'h0, m_mis[0]});
    chk("mis1", {31'h0, mis1}, {31'h0, m_mis[1]});
  endtask

  task automatic cyc(input logic r, input logic b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic s, input logic rd);
    rst = r; br = b; bta = bt; jmp = j; ja = jt; stall = s; rdy = rd;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic        r_b, r_j, r_mis;
    logic [31:0] r_t1, r_t2;
    m_rp[0] = 32'h0; m_rp[1] = RP1;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 32'h0; m_skid[d] = 32'h0; m_ins[d] = 32'h0; m_pp4[d] = 32'h0;
      m_hold[d] = 1'b0; m_vld[d] = 1'b0; m_mis[d] = 1'b0;
    end

    // reset
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_pc0", pc0, 32'h0000_0000);
    chk("rst_pc1", pc1, 32'hFFFF_FFFC);
    chk("rst_req", {31'h0, req0}, 32'h0);
    chk("rst_vld", {31'h0, vld0}, 32'h0);

    // back-to-back fetch, dut1 wraps through zero
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("f1_ins0", ins0, 32'hC0DE_0000);
    chk("f1_pp40", pp40, 32'h0000_0004);
    chk("f1_vld0", {31'h0, vld0}, 32'h1);
    chk("wrap_pc1", pc1, 32'h0000_0000);
    chk("wrap_pp41", pp41, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("f2_pp40", pp40, 32'h0000_0008);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("f3_pp40", pp40, 32'h0000_000C);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("f4_pc0", pc0, 32'h0000_0010);

    // stall with a returned word at 0x10
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("held_req0", {31'h0, req0}, 32'h0);
      chk("held_pp40", pp40, 32'h0000_0010);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rel_ins0", ins0, 32'hC0DE_0010);
    chk("rel_pp40", pp40, 32'h0000_0014);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("next_ins0", ins0, 32'hC0DE_0014);

    // branch from 0x20 to 0x100
    for (int i = 0; i < 8 && m_pc[0] != 32'h20; i++)
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("at20_pc0", pc0, 32'h0000_0020);
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_pc0", pc0, 32'h0000_0100);
    chk("br_vld0", {31'h0, vld0}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("br_ins0", ins0, 32'hC0DE_0100);
    chk("br_pp40", pp40, 32'h0000_0104);

    // jump + branch together while stalled in HELD
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    chk("jb_pc0", pc0, 32'h0000_0400);
    chk("jb_mis0", {31'h0, mis0}, 32'h0);
    chk("jb_req0", {31'h0, req0}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("jb_ins0", ins0, 32'hC0DE_0400);

    // misaligned redirect is sticky
    cyc(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("mis_pc0", pc0, 32'h0000_0100);
    chk("mis_set", {31'h0, mis0}, 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("mis_stays", {31'h0, mis0}, 32'h1);

    // reset pulsed while HELD
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("hrst_pc1", pc1, 32'hFFFF_FFFC);
    chk("hrst_mis0", {31'h0, mis0}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hrst_vld0", {31'h0, vld0}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("hrst_ins0", ins0, 32'hC0DE_0000);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r_b   = ($urandom_range(0, 9) == 0);
      r_j   = ($urandom_range(0, 14) == 0);
      r_mis = ($urandom_range(0, 3) == 0);
      r_t1  = $urandom;
      r_t2  = $urandom;
      if (!r_mis) begin
        r_t1[1:0] = 2'b00;
        r_t2[1:0] = 2'b00;
      end
      cyc($urandom_range(0, 99) == 0, r_b, r_t1, r_j, r_t2,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch stage of the pipelined MIPS core: holds the program counter, issues instruction-memory requests and fills the IF/ID pipeline register. It consumes the branch target address and jump address produced by the branch/jump calculators, redirecting fetch and flushing IF/ID on a taken branch or jump. A single-entry skid buffer absorbs the hazard unit's stall so that no fetched instruction is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush/reset
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- In_branch_taken  in  1  branch resolved taken this cycle
- In_BTA  in  32  branch target address
- In_jump  in  1  jump resolved this cycle
- In_Jump_Address  in  32  jump target address
- In_stall  in  1  hazard-unit stall: hold PC and IF/ID
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= PC)
- imem_ready  in  1  imem_rdata valid for imem_addr this cycle
- imem_rdata  in  32  instruction word
- PC  out  32  current fetch PC
- IFID_instruction  out  32  registered instruction
- IFID_pc_plus_4  out  32  registered PC+4 of that instruction
- IFID_valid  out  1  IF/ID holds a real instruction
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- redirect = In_branch_taken | In_jump; target = In_jump ? In_Jump_Address : In_BTA (jump wins if both).
- Redirect priority over stall and over any fetch completion in the same cycle.
- Imem contract: request is level-based; memory may respond any cycle; request may change or be dropped any cycle without obligation.
- FSM states: REQ, HELD.
- REQ: imem_req=1, imem_addr=PC.
  - redirect: PC<=target & ~3; IFID_instruction<=NOP_INSTR, IFID_valid<=0, IFID_pc_plus_4 unchanged; imem_rdata discarded; stay REQ.
  - imem_ready & !In_stall: IF/ID<={imem_rdata, PC+4, 1}; PC<=PC+4; stay REQ.
  - imem_ready & In_stall: skid<=imem_rdata; IF/ID holds; PC holds; go HELD.
  - !imem_ready & In_stall: IF/ID and PC hold; stay REQ.
  - !imem_ready & !In_stall: IFID_valid<=0 (bubble), PC holds; stay REQ.
- HELD: imem_req=0.
  - redirect: as in REQ; skid discarded; go REQ.
  - !In_stall: IF/ID<={skid, PC+4, 1}; PC<=PC+4; go REQ.
  - In_stall: hold everything.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- misalign_err set when a redirect target has [1:0] != 0; cleared only by reset; PC always word-aligned.

## Timing
- Reset values: PC=RESET_PC, state REQ, IFID_instruction=NOP_INSTR, IFID_pc_plus_4=0, IFID_valid=0, misalign_err=0, skid=0. imem_req=0 while reset high, 1 in first cycle after release.
- imem_req/imem_addr combinational from state/PC only (no input-to-output paths).
- Fetch latency: word accepted in cycle N (imem_ready=1) appears on IF/ID after edge N.
- Throughput: 1 instruction/cycle with imem_ready held high and no stall.
- Redirect in cycle N: PC=target and IFID_valid=0 after edge N; target's instruction in IF/ID after edge N+1 at earliest.
- Stall release from HELD: buffered instruction in IF/ID after the first edge with In_stall=0; no imem request issued that cycle.
- Reset asserted mid-stall or mid-HELD: skid and FSM cleared immediately; no buffered instruction emitted.

## Test plan
- Reset release, imem_ready=1 always, rdata=addr: IF/ID shows (0,4),(4,8),(8,12) in consecutive cycles, IFID_valid=1 from second cycle.
- Stall with imem_ready=1 at PC=0x10 for 3 cycles: IF/ID holds prior word, imem_req=0 during HELD, then 0x10 word appears once, next fetch 0x14; no duplicates or drops.
- In_branch_taken=1, In_BTA=0x100 at PC=0x20: IFID_valid=0 next cycle, PC=0x100, then instruction at 0x100 with IFID_pc_plus_4=0x104.
- In_jump and In_branch_taken together (Jump=0x400, BTA=0x200) while In_stall=1 in HELD: PC=0x400, skid discarded, misalign_err=0.
- Redirect to 0x103: PC=0x100, misalign_err=1 and stays 1 through later redirects until reset.
- RESET_PC=32'hFFFF_FFFC, ready always: PC wraps to 0, IFID_pc_plus_4=0 for first instruction; reset pulsed mid-HELD returns to RESET_PC with IFID_valid=0.
